// File: rtl/seqn_pkg.sv
// Shared types and defaults for the 1010 hit monitor.
package seqn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int unsigned WIN_LEN_DEF = 32;
    localparam int unsigned CNT_W_DEF   = 8;
    localparam int unsigned LOST_W      = 8;

endpackage

// File: rtl/seqn_rpt_slot.sv
// Single-entry report holder with consume-and-reload and a drop counter.
module seqn_rpt_slot
    import seqn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic [CNT_W-1:0]  cnt_i,
    input  logic              sat_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic              sat_o,
    output logic [LOST_W-1:0] lost_o
);

    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic [LOST_W-1:0] lost_q, lost_d;

    always_comb begin
        valid_d = valid_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        lost_d  = lost_q;
        if (load_i) begin
            // A ready consumer frees the slot on the same edge.
            if (!valid_q || ready_i) begin
                valid_d = 1'b1;
                cnt_d   = cnt_i;
                sat_d   = sat_i;
            end else if (lost_q != '1) begin
                lost_d = lost_q + 1'b1;
            end
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            lost_q  <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            lost_q  <= lost_d;
        end
    end

    assign valid_o = valid_q;
    assign cnt_o   = cnt_q;
    assign sat_o   = sat_q;
    assign lost_o  = lost_q;

endmodule

// File: rtl/seqn_hit_monitor.sv
// Counts detector hits per fixed window and hands each window to a report slot.
module seqn_hit_monitor
    import seqn_pkg::*;
#(
    parameter int WIN_LEN = WIN_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit,
    input  logic              en,
    input  logic              rpt_ready,
    output logic              rpt_valid,
    output logic [CNT_W-1:0]  rpt_count,
    output logic              rpt_sat,
    output logic [LOST_W-1:0] lost_cnt,
    output logic              busy
);

    localparam int WW = $clog2(WIN_LEN);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);

    state_e           state_q, state_d;
    logic [WW-1:0]    win_q, win_d;
    logic [CNT_W-1:0] hit_q, hit_d;
    logic             sat_q, sat_d;

    logic             close;
    logic [CNT_W-1:0] cnt_n;
    logic             sat_n;

    always_comb begin
        cnt_n = hit_q;
        sat_n = sat_q;
        if (hit) begin
            if (hit_q == '1) begin
                sat_n = 1'b1;
            end else begin
                cnt_n = hit_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        hit_d   = hit_q;
        sat_d   = sat_q;
        close   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = RUN;
                    win_d   = '0;
                    hit_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            RUN: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (win_q == WIN_LAST) begin
                    // Close cycle hit goes into cnt_n, not the next window.
                    close = 1'b1;
                    win_d = '0;
                    hit_d = '0;
                    sat_d = 1'b0;
                end else begin
                    win_d = win_q + 1'b1;
                    hit_d = cnt_n;
                    sat_d = sat_n;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            win_q   <= '0;
            hit_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            hit_q   <= hit_d;
            sat_q   <= sat_d;
        end
    end

    assign busy = (state_q == RUN);

    seqn_rpt_slot #(
        .CNT_W (CNT_W)
    ) u_slot (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (close),
        .cnt_i   (cnt_n),
        .sat_i   (sat_n),
        .ready_i (rpt_ready),
        .valid_o (rpt_valid),
        .cnt_o   (rpt_count),
        .sat_o   (rpt_sat),
        .lost_o  (lost_cnt)
    );

endmodule

// File: tb/tb_seqn_hit_monitor.sv
// Directed scoreboard bench for seqn_hit_monitor (WIN_LEN=8, CNT_W=4 and 2).
module tb_seqn_hit_monitor;

    typedef struct packed {
        logic [3:0] cnt;
        logic       sat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       rpt_ready;
    logic       hit_drv;
    logic       use_det;
    logic       din;
    logic [2:0] sh;
    logic       y_q;
    logic       hit;

    logic       m_valid, m_sat, m_busy;
    logic [3:0] m_count;
    logic [7:0] m_lost;
    logic       s_valid, s_sat, s_busy;
    logic [1:0] s_count;
    logic [7:0] s_lost;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Reference 1010 detector with registered output y.
    always @(posedge clk) begin
        if (reset) begin
            sh  <= 3'b000;
            y_q <= 1'b0;
        end else begin
            sh  <= {sh[1:0], din};
            y_q <= ({sh, din} == 4'b1010);
        end
    end

    assign hit = use_det ? y_q : hit_drv;

    seqn_hit_monitor #(.WIN_LEN(8), .CNT_W(4)) u_main (
        .clk       (clk),
        .reset     (reset),
        .hit       (hit),
        .en        (en),
        .rpt_ready (rpt_ready),
        .rpt_valid (m_valid),
        .rpt_count (m_count),
        .rpt_sat   (m_sat),
        .lost_cnt  (m_lost),
        .busy      (m_busy)
    );

    seqn_hit_monitor #(.WIN_LEN(8), .CNT_W(2)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .hit       (hit),
        .en        (en),
        .rpt_ready (rpt_ready),
        .rpt_valid (s_valid),
        .rpt_count (s_count),
        .rpt_sat   (s_sat),
        .lost_cnt  (s_lost),
        .busy      (s_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        exp_t e;
        if (!reset && m_valid && rpt_ready) begin
            chk("sb_nonempty", (q.size() != 0), 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("sb_count", m_count, e.cnt);
                chk("sb_sat", m_sat, e.sat);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        en        = 1'b0;
        hit_drv   = 1'b0;
        rpt_ready = 1'b0;
        use_det   = 1'b0;
        din       = 1'b0;
        q.delete();
        cyc();
        reset = 1'b0;
    endtask

    logic [15:0] pat;

    initial begin
        pat = 16'b1010101000000000;
        @(negedge clk);

        do_reset();
        chk("rst_valid", m_valid, 0);
        chk("rst_count", m_count, 0);
        chk("rst_sat", m_sat, 0);
        chk("rst_lost", m_lost, 0);
        chk("rst_busy", m_busy, 0);

        // Detector stream: window 1 sees 2 hits, window 2 sees 1.
        rpt_ready = 1'b1;
        use_det   = 1'b1;
        en        = 1'b1;
        cyc();
        chk("s1_busy", m_busy, 1);
        q.push_back('{cnt: 4'd2, sat: 1'b0});
        q.push_back('{cnt: 4'd1, sat: 1'b0});
        for (int k = 0; k < 16; k++) begin
            din = pat[15-k];
            cyc();
            if (k == 6) chk("s1_valid_pre", m_valid, 0);
            if (k == 7) chk("s1_valid_post", m_valid, 1);
        end
        din = 1'b0;
        en  = 1'b0;
        cyc();
        cyc();
        use_det = 1'b0;

        // All-hit window, including the IDLE cycle where en rises.
        do_reset();
        rpt_ready = 1'b1;
        en        = 1'b1;
        hit_drv   = 1'b1;
        q.push_back('{cnt: 4'd8, sat: 1'b0});
        repeat (9) cyc();
        hit_drv = 1'b0;
        en      = 1'b0;
        chk("s2_m_valid", m_valid, 1);
        chk("s2_s_valid", s_valid, 1);
        chk("s2_s_count", s_count, 3);
        chk("s2_s_sat", s_sat, 1);
        cyc();
        cyc();

        // Stalled consumer across three closes, released at the fourth.
        do_reset();
        en = 1'b1;
        cyc();
        q.push_back('{cnt: 4'd1, sat: 1'b0});
        for (int w = 1; w <= 4; w++) begin
            for (int c = 0; c < 8; c++) begin
                hit_drv   = (c < w);
                rpt_ready = (w == 4 && c == 7);
                if (w == 4 && c == 7)
                    q.push_back('{cnt: 4'd4, sat: 1'b0});
                cyc();
                if (w > 1 && !(w == 4 && c == 7))
                    chk("s3_hold", {m_valid, m_count}, {1'b1, 4'd1});
                if (w == 3 && c == 7) chk("s3_lost3", m_lost, 2);
            end
        end
        chk("s3_lost4", m_lost, 2);
        chk("s3_new", {m_valid, m_count}, {1'b1, 4'd4});
        hit_drv   = 1'b0;
        en        = 1'b0;
        rpt_ready = 1'b1;
        cyc();
        cyc();

        // Early en drop discards the partial window, keeps the report.
        do_reset();
        en = 1'b1;
        cyc();
        q.push_back('{cnt: 4'd2, sat: 1'b0});
        for (int c = 0; c < 8; c++) begin
            hit_drv = (c < 2);
            cyc();
        end
        for (int c = 0; c < 5; c++) begin
            hit_drv = (c < 3);
            cyc();
        end
        en      = 1'b0;
        hit_drv = 1'b0;
        cyc();
        chk("s4_busy", m_busy, 0);
        chk("s4_keep", {m_valid, m_count}, {1'b1, 4'd2});
        cyc();
        cyc();
        en = 1'b1;
        cyc();
        chk("s4_rerun", m_busy, 1);
        q.push_back('{cnt: 4'd1, sat: 1'b0});
        for (int c = 0; c < 8; c++) begin
            hit_drv   = (c == 7);
            rpt_ready = (c == 7);
            cyc();
        end
        chk("s4_new", {m_valid, m_count, m_lost}, {1'b1, 4'd1, 8'd0});
        hit_drv   = 1'b0;
        en        = 1'b0;
        rpt_ready = 1'b1;
        cyc();
        cyc();

        // lost_cnt saturation.
        do_reset();
        en = 1'b1;
        cyc();
        repeat (8 * 260) cyc();
        chk("s5_lost_sat", m_lost, 255);

        // Reset mid-window with a pending report and lost_cnt=7.
        do_reset();
        en = 1'b1;
        cyc();
        hit_drv = 1'b1;
        repeat (8) cyc();
        hit_drv = 1'b0;
        repeat (60) cyc();
        chk("s6_pre", {m_valid, m_count, m_lost}, {1'b1, 4'd8, 8'd7});
        reset = 1'b1;
        q.delete();
        hit_drv   = 1'b1;
        rpt_ready = 1'b1;
        cyc();
        chk("s6_rst", {m_valid, m_count, m_sat, m_lost, m_busy}, 0);
        reset   = 1'b0;
        hit_drv = 1'b0;

        // First window after reset; hit only in the close cycle.
        cyc();
        chk("s7_busy", m_busy, 1);
        q.push_back('{cnt: 4'd1, sat: 1'b0});
        q.push_back('{cnt: 4'd0, sat: 1'b0});
        for (int c = 0; c < 16; c++) begin
            hit_drv = (c == 7);
            cyc();
            if (c == 7) chk("s7_valid", m_valid, 1);
        end
        hit_drv = 1'b0;
        en      = 1'b0;
        cyc();
        cyc();

        chk("sb_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
